inst_encoder: RTL

//  Streaming RV32I instruction encoder and program loader; the inverse of immediate decode.

---
 rtl/inst_encoder_pkg.sv | 36 +++
 rtl/inst_encoder_imm_pack.sv | 42 ++++
 rtl/inst_encoder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: format codes,
// base opcodes and FSM state encodings.
package inst_encoder_pkg;

    typedef logic [1:0] fmt_t;
    typedef logic [1:0] fsm_state_t;

    // Field-bundle format selector
    localparam fmt_t FMT_LOAD   = 2'd0;
    localparam fmt_t FMT_OPIMM  = 2'd1;
    localparam fmt_t FMT_STORE  = 2'd2;
    localparam fmt_t FMT_BRANCH = 2'd3;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Loader FSM states
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_RUN  = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    function automatic logic [6:0] fmt_opcode(input fmt_t fmt);
        logic [6:0] op;
        case (fmt)
            FMT_LOAD:  op = OPC_LOAD;
            FMT_OPIMM: op = OPC_OPIMM;
            FMT_STORE: op = OPC_STORE;
            default:   op = OPC_BRANCH;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Scatters a 32-bit signed immediate into the I/S/B instruction bit layout
// and reports whether the value is representable in that format.
module inst_encoder_imm_pack
    import inst_encoder_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [31:0] imm_i,
    output logic [31:0] imm_bits_o,
    output logic        range_ok_o
);

    logic i_fits;
    logic b_fits;

    assign i_fits = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign b_fits = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];

    // Place immediate bits; all non-immediate positions stay zero
    always_comb begin
        imm_bits_o = '0;
        range_ok_o = 1'b0;
        case (fmt_i)
            FMT_LOAD, FMT_OPIMM: begin
                imm_bits_o[31:20] = imm_i[11:0];
                range_ok_o        = i_fits;
            end
            FMT_STORE: begin
                imm_bits_o[31:25] = imm_i[11:5];
                imm_bits_o[11:7]  = imm_i[4:0];
                range_ok_o        = i_fits;
            end
            default: begin
                imm_bits_o[31]    = imm_i[12];
                imm_bits_o[30:25] = imm_i[10:5];
                imm_bits_o[11:8]  = imm_i[4:1];
                imm_bits_o[7]     = imm_i[11];
                range_ok_o        = b_fits;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder / program loader. Accepts decoded
// field bundles, encodes them and writes words to instruction memory at
// incrementing word-aligned addresses starting from BASE_ADDR.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        err,
    output logic [30:0] word_cnt
);

    fsm_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [30:0] cnt_q, cnt_d;
    logic        last_q, last_d;

    logic [31:0] imm_bits;
    logic        range_ok;
    logic [31:0] enc_word;
    logic [31:0] queued;
    logic        full;
    logic        wr_fire;
    logic        accept;
    logic        keep;
    logic        drop;

    inst_encoder_imm_pack u_imm_pack (
        .fmt_i      (in_fmt),
        .imm_i      (in_imm),
        .imm_bits_o (imm_bits),
        .range_ok_o (range_ok)
    );

    // Merge register/funct3/opcode fields around the scattered immediate
    always_comb begin
        enc_word        = imm_bits;
        enc_word[19:15] = in_rs1;
        enc_word[14:12] = in_funct3;
        enc_word[6:0]   = fmt_opcode(in_fmt);
        case (in_fmt)
            FMT_LOAD, FMT_OPIMM: enc_word[11:7]  = in_rd;
            default:             enc_word[24:20] = in_rs2;
        endcase
    end

    // Words committed so far, including one still waiting on mem_ready
    assign queued  = {1'b0, cnt_q} + {31'b0, we_q};
    assign full    = (queued == DEPTH);
    assign wr_fire = we_q & mem_ready;
    // last_q blocks further bundles while the final word drains
    assign in_ready = (state_q == ST_RUN) && !last_q && (!we_q || mem_ready);
    assign accept   = in_valid & in_ready;
    assign keep     = accept & range_ok & ~full;
    assign drop     = accept & ~keep;

    // Next-state: write handshake, bundle intake, FSM, start override
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        if (wr_fire) begin
            we_d   = 1'b0;
            addr_d = addr_q + 32'd4;
            cnt_d  = cnt_q + 31'd1;
        end
        if (keep) begin
            we_d    = 1'b1;
            wdata_d = enc_word;
        end
        if (drop) begin
            err_d = 1'b1;
        end
        if (accept && in_last) begin
            last_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (last_d && !we_d) begin
                    state_d = ST_DONE;
                    last_d  = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase

        if (start) begin
            state_d = ST_RUN;
            we_d    = 1'b0;
            addr_d  = BASE_ADDR;
            cnt_d   = '0;
            err_d   = 1'b0;
            last_d  = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign word_cnt  = cnt_q;

endmodule
